mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, giving the word-address width; memory depth SHALL be 2**ADDR_W words.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the word width.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ld_valid  input  1  loader word valid.
REQ-007 ld_data  input  DATA_W  loader word.
REQ-008 ld_last  input  1  marks the final loader word, qualified by ld_valid.
REQ-009 ld_ready  output  1  loader may transfer this cycle.
REQ-010 reload  input  1  single-cycle request to return to program-load mode.
REQ-011 cpu_rst_n  output  1  active-low reset to the CPU.
REQ-012 start_pc  output  ADDR_W  CPU start address.
REQ-013 pc  input  ADDR_W  CPU instruction fetch address.
REQ-014 instr  output  DATA_W  fetched instruction word.
REQ-015 ram_addr2  input  ADDR_W  CPU data-port address.
REQ-016 ram_w_en2  input  1  CPU data-port write enable.
REQ-017 ram_in2  input  DATA_W  CPU data-port write data.
REQ-018 ram_data2  output  DATA_W  CPU data-port read data.
REQ-019 waiting  input  1  CPU idle/halted indicator.
REQ-020 done  output  1  high while in RUN and waiting is high.
REQ-021 ld_ovf  output  1  sticky flag: load filled memory without ld_last.
REQ-022 state  output  1  current state, LOAD=0, RUN=1.

Function
REQ-023 The FSM SHALL have exactly two states: LOAD and RUN.
REQ-024 In LOAD: ld_ready=1; a transfer occurs when ld_valid&&ld_ready; each transfer writes ld_data to mem[ld_addr], then increments internal ld_addr.
REQ-025 A transfer with ld_last=1 SHALL move LOAD->RUN on that same edge.
REQ-026 A transfer at ld_addr=2**ADDR_W-1 without ld_last SHALL move LOAD->RUN, set ld_ovf, and leave ld_addr at 0 (wrap).
REQ-027 cpu_rst_n SHALL be registered, 0 in LOAD, 1 from the edge entering RUN onward.
REQ-028 In RUN: ld_ready=0; ld_valid SHALL be ignored and memory SHALL NOT be written by the loader.
REQ-029 In RUN: instr SHALL equal mem[pc] sampled at the previous edge (1-cycle latency).
REQ-030 In RUN: ram_data2 SHALL equal mem[ram_addr2] sampled at the previous edge (1-cycle latency).
REQ-031 In RUN with ram_w_en2=1: mem[ram_addr2] SHALL be written with ram_in2 at the edge.
REQ-032 Read-during-write, same address (data port or instruction port vs data-port write): read-first; the output SHALL return the old word, the new word visible the following cycle.
REQ-033 In LOAD: instr and ram_data2 SHALL be held at 0; ram_w_en2 SHALL be ignored.
REQ-034 reload=1 in RUN SHALL move RUN->LOAD at that edge, drive cpu_rst_n=0, clear ld_addr to 0, clear instr and ram_data2 to 0; memory contents SHALL be retained; ld_ovf SHALL be cleared.
REQ-035 reload=1 in LOAD SHALL restart loading: ld_addr cleared to 0; it takes priority over a simultaneous loader transfer (the word is dropped).
REQ-036 start_pc SHALL be constant 0.
REQ-037 done SHALL be combinational: (state==RUN)&&waiting.

Reset
REQ-038 On rst_n=0, immediately: state=LOAD, ld_addr=0, cpu_rst_n=0, instr=0, ram_data2=0, ld_ovf=0; ld_ready=1 once rst_n is released.
REQ-039 Memory contents SHALL NOT be reset.
REQ-040 Reset asserted mid-load or mid-run SHALL abort the activity; a partially loaded program requires a full reload.

Verification
REQ-041 Load 3 words 0xE3A00001, 0xE2800002, 0xEAFFFFFE (last on 3rd) -> ld_ready falls after 3rd edge, state=1, cpu_rst_n=1; pc=1 -> instr=0xE2800002 next cycle.
REQ-042 RUN, ram_w_en2=1, ram_addr2=0x010, ram_in2=0xDEADBEEF, then read 0x010 -> ram_data2=0xDEADBEEF one cycle after read address applied.
REQ-043 RUN, mem[0x020]=0x11111111; write 0x22222222 to 0x020 while pc=0x020 -> instr=0x11111111 next cycle, 0x22222222 the cycle after.
REQ-044 Stream 2048 words, no ld_last -> RUN entered after 2048th transfer, ld_ovf=1, ld_addr wraps to 0.
REQ-045 RUN, pulse reload -> cpu_rst_n=0, state=0, instr=0 next cycle; ld_ovf cleared; previously loaded words still read back after a 1-word reload.
REQ-046 Assert rst_n=0 mid-load after 5 words -> outputs at reset values immediately; after release, first transfer writes address 0.

Source files
------------

// File: rtl/mem_responder.sv
// Program memory that is filled by a streaming loader, then serves a CPU's
// instruction port and read/write data port once the CPU is released from reset.
module mem_responder #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload,
    output logic              cpu_rst_n,
    output logic [ADDR_W-1:0] start_pc,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    input  logic [ADDR_W-1:0] ram_addr2,
    input  logic              ram_w_en2,
    input  logic [DATA_W-1:0] ram_in2,
    output logic [DATA_W-1:0] ram_data2,
    input  logic              waiting,
    output logic              done,
    output logic              ld_ovf,
    output logic              state
);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic              ld_ovf_q, ld_ovf_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic [DATA_W-1:0] instr_q, ram_data2_q;
    logic              ld_we, cpu_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            ld_addr_q   <= '0;
            ld_ovf_q    <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_addr_q   <= ld_addr_d;
            ld_ovf_q    <= ld_ovf_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    // Reload wins over a simultaneous loader word; filling the last address
    // without ld_last still releases the CPU but flags the overflow.
    always_comb begin
        state_d   = state_q;
        ld_addr_d = ld_addr_q;
        ld_ovf_d  = ld_ovf_q;
        case (state_q)
            LOAD: begin
                if (reload) begin
                    ld_addr_d = '0;
                end else if (ld_valid) begin
                    ld_addr_d = ld_addr_q + 1'b1;
                    if (ld_last) begin
                        state_d = RUN;
                    end else if (ld_addr_q == LAST_ADDR) begin
                        state_d  = RUN;
                        ld_ovf_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (reload) begin
                    state_d   = LOAD;
                    ld_addr_d = '0;
                    ld_ovf_d  = 1'b0;
                end
            end
            default: state_d = LOAD;
        endcase
        cpu_rst_n_d = (state_d == RUN);
    end

    always_comb begin
        ld_ready = (state_q == LOAD);
        done     = (state_q == RUN) && waiting;
        ld_we    = (state_q == LOAD) && ld_valid && !reload;
        cpu_we   = (state_q == RUN) && ram_w_en2;
    end

    // Memory contents deliberately survive reset and reload.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr_q] <= ld_data;
        end else if (cpu_we) begin
            mem[ram_addr2] <= ram_in2;
        end
    end

    // Registered reads see the pre-write word, giving read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q     <= '0;
            ram_data2_q <= '0;
        end else if (state_q == RUN && !reload) begin
            instr_q     <= mem[pc];
            ram_data2_q <= mem[ram_addr2];
        end else begin
            instr_q     <= '0;
            ram_data2_q <= '0;
        end
    end

    assign cpu_rst_n = cpu_rst_n_q;
    assign start_pc  = '0;
    assign instr     = instr_q;
    assign ram_data2 = ram_data2_q;
    assign ld_ovf    = ld_ovf_q;
    assign state     = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: load, run, read-first, overflow, reload
// and asynchronous reset, each step checked against hand-computed values.
module tb_mem_responder;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              reload;
    logic              cpu_rst_n;
    logic [ADDR_W-1:0] start_pc;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] ram_addr2;
    logic              ram_w_en2;
    logic [DATA_W-1:0] ram_in2;
    logic [DATA_W-1:0] ram_data2;
    logic              waiting;
    logic              done;
    logic              ld_ovf;
    logic              state;

    int checks   = 0;
    int failures = 0;

    mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .reload    (reload),
        .cpu_rst_n (cpu_rst_n),
        .start_pc  (start_pc),
        .pc        (pc),
        .instr     (instr),
        .ram_addr2 (ram_addr2),
        .ram_w_en2 (ram_w_en2),
        .ram_in2   (ram_in2),
        .ram_data2 (ram_data2),
        .waiting   (waiting),
        .done      (done),
        .ld_ovf    (ld_ovf),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic loadWord(input logic [31:0] data, input logic last);
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        applyStimulus();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        reload = 1'b0; pc = '0; ram_addr2 = '0; ram_w_en2 = 1'b0;
        ram_in2 = '0; waiting = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_ram_data2", ram_data2, 32'd0);
        checkOutput("rst_ld_ovf", 32'(ld_ovf), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("start_pc", 32'(start_pc), 32'd0);
        applyStimulus();
        rst_n = 1'b1;
        #1;
        checkOutput("rst_ld_ready", 32'(ld_ready), 32'd1);

        $display("[TB] three-word program load");
        loadWord(32'hE3A00001, 1'b0);
        checkOutput("load1_ready", 32'(ld_ready), 32'd1);
        checkOutput("load1_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        loadWord(32'hE2800002, 1'b0);
        loadWord(32'hEAFFFFFE, 1'b1);
        checkOutput("load3_ready", 32'(ld_ready), 32'd0);
        checkOutput("load3_state", 32'(state), 32'd1);
        checkOutput("load3_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        checkOutput("load3_done", 32'(done), 32'd1);
        checkOutput("load3_instr_zero", instr, 32'd0);
        pc = 11'd1; ram_addr2 = 11'd2;
        applyStimulus();
        checkOutput("fetch_pc1", instr, 32'hE2800002);
        checkOutput("data_rd2", ram_data2, 32'hEAFFFFFE);
        waiting = 1'b0;
        #1;
        checkOutput("done_low", 32'(done), 32'd0);
        waiting = 1'b1;

        $display("[TB] data-port write then read");
        ram_w_en2 = 1'b1; ram_addr2 = 11'h010; ram_in2 = 32'hDEADBEEF;
        applyStimulus();
        ram_w_en2 = 1'b0;
        applyStimulus();
        checkOutput("wr_rd_010", ram_data2, 32'hDEADBEEF);

        $display("[TB] loader ignored in RUN");
        ram_w_en2 = 1'b1; ram_addr2 = 11'd3; ram_in2 = 32'h33333333;
        applyStimulus();
        ram_w_en2 = 1'b0;
        ld_valid = 1'b1; ld_data = 32'hBADBAD00;
        applyStimulus();
        ld_valid = 1'b0;
        applyStimulus();
        checkOutput("run_ld_ignored", ram_data2, 32'h33333333);
        checkOutput("run_ld_state", 32'(state), 32'd1);

        $display("[TB] read-during-write at 0x020");
        ram_w_en2 = 1'b1; ram_addr2 = 11'h020; ram_in2 = 32'h11111111;
        applyStimulus();
        pc = 11'h020; ram_in2 = 32'h22222222;
        applyStimulus();
        ram_w_en2 = 1'b0;
        checkOutput("rdw_instr_old", instr, 32'h11111111);
        checkOutput("rdw_data_old", ram_data2, 32'h11111111);
        applyStimulus();
        checkOutput("rdw_instr_new", instr, 32'h22222222);

        $display("[TB] reload from RUN and one-word reload");
        reload = 1'b1;
        applyStimulus();
        reload = 1'b0;
        checkOutput("reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("reload_state", 32'(state), 32'd0);
        checkOutput("reload_instr", instr, 32'd0);
        checkOutput("reload_data", ram_data2, 32'd0);
        checkOutput("reload_ready", 32'(ld_ready), 32'd1);
        loadWord(32'hAAAA0000, 1'b1);
        checkOutput("reload1_state", 32'(state), 32'd1);
        pc = 11'd1; ram_addr2 = 11'h010;
        applyStimulus();
        checkOutput("retain_pc1", instr, 32'hE2800002);
        checkOutput("retain_010", ram_data2, 32'hDEADBEEF);
        pc = 11'd0;
        applyStimulus();
        checkOutput("reload_word0", instr, 32'hAAAA0000);

        $display("[TB] reload in LOAD drops simultaneous word");
        reload = 1'b1;
        applyStimulus();
        ld_valid = 1'b1; ld_data = 32'h55555555; ld_last = 1'b1;
        applyStimulus();
        reload = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        checkOutput("reload_prio_state", 32'(state), 32'd0);
        loadWord(32'h66666666, 1'b1);
        pc = 11'd0;
        applyStimulus();
        checkOutput("reload_prio_word0", instr, 32'h66666666);

        $display("[TB] overflow stream of 2048 words");
        reload = 1'b1;
        applyStimulus();
        reload = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            loadWord(32'hA5000000 ^ 32'(i), 1'b0);
            if (i == 2046) checkOutput("ovf_not_yet", 32'(state), 32'd0);
        end
        checkOutput("ovf_state", 32'(state), 32'd1);
        checkOutput("ovf_flag", 32'(ld_ovf), 32'd1);
        checkOutput("ovf_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        checkOutput("ovf_addr_wrap", 32'(dut.ld_addr_q), 32'd0);
        pc = 11'h7FF; ram_addr2 = 11'h000;
        applyStimulus();
        checkOutput("ovf_top_word", instr, 32'hA50007FF);
        checkOutput("ovf_word0", ram_data2, 32'hA5000000);

        $display("[TB] reload clears overflow");
        reload = 1'b1;
        applyStimulus();
        reload = 1'b0;
        checkOutput("ovf_cleared", 32'(ld_ovf), 32'd0);
        loadWord(32'h12345678, 1'b1);
        pc = 11'h7FF;
        applyStimulus();
        checkOutput("after_ovf_instr", instr, 32'hA50007FF);

        $display("[TB] asynchronous reset mid-run");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("runrst_instr", instr, 32'd0);
        checkOutput("runrst_state", 32'(state), 32'd0);
        checkOutput("runrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        rst_n = 1'b1;

        $display("[TB] asynchronous reset mid-load");
        for (int i = 0; i < 5; i++) loadWord(32'hC0 + 32'(i), 1'b0);
        checkOutput("midload_state", 32'(state), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midload_addr", 32'(dut.ld_addr_q), 32'd0);
        checkOutput("midload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        checkOutput("midload_ovf", 32'(ld_ovf), 32'd0);
        rst_n = 1'b1;
        loadWord(32'h77777777, 1'b1);
        pc = 11'd1;
        applyStimulus();
        checkOutput("midload_keep1", instr, 32'h000000C1);
        pc = 11'd0;
        applyStimulus();
        checkOutput("midload_addr0", instr, 32'h77777777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
